bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//   Shares the peripheral bus (vga_text, keyboard, seven_seg_perpherial) between NM requesters.
//   Master 0 is the datapath load/store port; master 1 is reserved for a future DMA/blit engine.
//   The block does round-robin arbitration and sequences one transaction at a time.
//   It also decodes the address to a one-hot peripheral select, handles wait states and
//   times out hung accesses. It sits in core between the masters and the peripheral bus.
// PARAMETERS
//   NM        2         number of requesters
//   AW        64        address width
//   DW        64        data width
//   TIMEOUT   16        max consecutive bus_wait cycles before abort (>=1)
//   VGA_BASE  'h1       addr[AW-1:12] value selecting vga_text (4 KiB region)
//   KBD_BASE  'h2       addr[AW-1:12] value selecting keyboard
//   SEG_BASE  'h3       addr[AW-1:12] value selecting seven segment
// PORTS
//   clock      in   1      system clock, all state on rising edge
//   reset      in   1      asynchronous, active-low reset
//   m_req      in   NM     per-master request; held until m_done
//   m_write    in   NM     1=write, 0=read
//   m_addr     in   NM*AW  flattened addresses, master i at [i*AW +: AW]
//   m_wdata    in   NM*DW  flattened write data
//   m_grant    out  NM     one-hot owner of the current transaction
//   m_done     out  NM     1-cycle completion pulse to the owner
//   m_err      out  NM     with m_done: unmapped address or timeout
//   m_rdata    out  DW     read data, valid while m_done is high
//   bus_addr   out  AW     peripheral address
//   bus_wdata  out  DW     peripheral write data
//   bus_rdata  in   DW     peripheral read data
//   bus_read   out  1      read strobe
//   bus_write  out  1      write strobe
//   bus_wait   in   1      peripheral stall; extends the strobe
//   bus_sel    out  3      one-hot {seg,kbd,vga} select
// BEHAVIOUR
//   Reset (async, low): state=IDLE, ptr=0, counters=0. Every output is 0 immediately.
//     Reset in mid-transaction drops the strobes at once and issues no m_done.
//   FSM IDLE -> ACCESS -> DONE -> IDLE. Unmapped addresses go IDLE -> DONE.
//   IDLE: if |m_req, winner = first requesting index at or after ptr, cyclic.
//     At the edge the block latches idx, addr, wdata, write and the decoded sel.
//     Mapped address -> ACCESS. Unmapped -> DONE with err=1, no strobe, bus_sel=0.
//   ACCESS: bus_addr, bus_wdata and bus_sel are driven from the latches.
//     bus_read or bus_write is high for the whole state.
//     At an edge with bus_wait=0: capture bus_rdata (reads only, writes capture 0) -> DONE.
//     At an edge with bus_wait=1: wcnt++. When wcnt reaches TIMEOUT -> DONE, err=1, rdata=0.
//   DONE: m_done[idx]=1 for exactly 1 cycle, with m_err[idx] and m_rdata.
//     Strobes and bus_sel are 0. ptr <= (idx+1) mod NM, wcnt <= 0 -> IDLE.
//   m_grant[idx] is high from ACCESS (or the unmapped DONE) through DONE; 0 in IDLE.
//   Latency with zero wait: req seen at edge 0, strobe in cycle 1, m_done in cycle 2.
//     Each wait cycle adds 1. A master is serviced at most every 3 cycles.
//   A master drops m_req on the edge where it samples m_done. The block samples m_req only in IDLE.
//     A master deasserting m_req mid-transaction is ignored; the transaction completes.
//   m_addr, m_wdata and m_write are sampled only at the IDLE grant edge.
//   Two or more requests in the same cycle: the ptr rule decides; the losers wait with no starvation.
//     Worst-case wait is (NM-1) transactions.
//   Outputs in IDLE: bus_addr, bus_wdata and m_rdata are 0 (no stale data on the bus).
//   Width rules: wcnt is $clog2(TIMEOUT+1) bits, saturating; ptr is $clog2(NM) bits (min 1).
//     Decode compares addr[AW-1:12] exactly against each BASE.
// STRUCTURE
//   bus_pkg: state encodings (IDLE/ACCESS/DONE), SEL_VGA/KBD/SEG bit indices,
//     default region bases and the region shift (12).
//   Sub-module rr_pick: combinational (req[NM], ptr) -> one-hot grant plus an index.
//   The FSM, latches, decoder and timeout counter live in bus_arbiter.
// TESTING
//   1 m0 reads 'h2010 with wait=0 and bus_rdata='h41
//     -> bus_read and bus_sel=3'b010 in cycle 1 only; m_done[0]=1 in cycle 2, m_rdata='h41, m_err=0.
//   2 m0 and m1 request continuously for 3 transactions after reset
//     -> grant order 0,1,0; m_done pulses at cycles 2, 5 and 8.
//   3 m1 writes 'h3000 <- 'h1234 with bus_wait high for 3 cycles
//     -> bus_write high for cycles 1-4, bus_wdata='h1234, m_done[1] in cycle 5.
//   4 m0 reads 'h1000 with bus_wait stuck at 1
//     -> strobe drops after 16 wait edges; m_done[0]=1, m_err[0]=1, m_rdata=0.
//   5 m0 accesses 'hDEAD_0000 -> m_done[0] and m_err[0] in cycle 1; no strobe ever; bus_sel=0.
//   6 reset pulled low during an ACCESS wait -> all outputs 0 in the same cycle;
//     after release, a new m1 request completes normally with ptr=0 arbitration.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings for the peripheral bus arbiter: FSM states, select bit
// positions and the default 4 KiB region map.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int SEL_VGA = 0;
    localparam int SEL_KBD = 1;
    localparam int SEL_SEG = 2;
    localparam int SEL_W   = 3;

    localparam int REGION_SHIFT = 12;

    localparam logic [63:0] DEF_VGA_BASE = 64'h1;
    localparam logic [63:0] DEF_KBD_BASE = 64'h2;
    localparam logic [63:0] DEF_SEG_BASE = 64'h3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_pick
    import bus_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = idx_width(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan a doubled index range so the wrap needs no modulo on ptr itself.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < 2 * NM; k++) begin
            if (!valid && (k >= int'(ptr)) && (k < int'(ptr) + NM) && req[k % NM]) begin
                valid           = 1'b1;
                grant[k % NM]   = 1'b1;
                idx             = IW'(k % NM);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the peripheral bus: one transaction at a time, with
// address decode to a one-hot peripheral select, wait states and a hang timeout.
//
// state     | meaning
// ST_IDLE   | no owner; sample m_req and latch the winner's request
// ST_ACCESS | strobe on the bus until bus_wait drops or the wait budget runs out
// ST_DONE   | one-cycle completion pulse to the owner, advance ptr
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int          NM       = 2,
    parameter int          AW       = 64,
    parameter int          DW       = 64,
    parameter int          TIMEOUT  = 16,
    parameter logic [63:0] VGA_BASE = DEF_VGA_BASE,
    parameter logic [63:0] KBD_BASE = DEF_KBD_BASE,
    parameter logic [63:0] SEG_BASE = DEF_SEG_BASE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NM-1:0]    m_req,
    input  logic [NM-1:0]    m_write,
    input  logic [NM*AW-1:0] m_addr,
    input  logic [NM*DW-1:0] m_wdata,
    output logic [NM-1:0]    m_grant,
    output logic [NM-1:0]    m_done,
    output logic [NM-1:0]    m_err,
    output logic [DW-1:0]    m_rdata,
    output logic [AW-1:0]    bus_addr,
    output logic [DW-1:0]    bus_wdata,
    input  logic [DW-1:0]    bus_rdata,
    output logic             bus_read,
    output logic             bus_write,
    input  logic             bus_wait,
    output logic [SEL_W-1:0] bus_sel
);

    localparam int IW = idx_width(NM);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int RW = AW - REGION_SHIFT;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   lat_idx;
    logic [WW-1:0]   wcnt;

    logic [NM-1:0]    pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [AW-1:0]    pick_addr;
    logic [DW-1:0]    pick_wdata;
    logic             pick_write;
    logic [SEL_W-1:0] pick_sel;
    logic             wait_expire;

    rr_pick #(.NM(NM), .IW(IW)) u_pick (
        .req   (m_req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_addr  = m_addr[int'(pick_idx) * AW +: AW];
    assign pick_wdata = m_wdata[int'(pick_idx) * DW +: DW];
    assign pick_write = m_write[pick_idx];

    always_comb begin
        pick_sel = '0;
        pick_sel[SEL_VGA] = (pick_addr[AW-1:REGION_SHIFT] == VGA_BASE[RW-1:0]);
        pick_sel[SEL_KBD] = (pick_addr[AW-1:REGION_SHIFT] == KBD_BASE[RW-1:0]);
        pick_sel[SEL_SEG] = (pick_addr[AW-1:REGION_SHIFT] == SEG_BASE[RW-1:0]);
    end

    // The edge that would bring wcnt up to TIMEOUT ends the access.
    assign wait_expire = bus_wait && (wcnt >= WW'(TIMEOUT - 1));

    // The bus_* output registers double as the latched request while in ST_ACCESS.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            lat_idx   <= '0;
            wcnt      <= '0;
            m_grant   <= '0;
            m_done    <= '0;
            m_err     <= '0;
            m_rdata   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_sel   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        lat_idx <= pick_idx;
                        m_grant <= pick_grant;
                        if (pick_sel != '0) begin
                            state     <= ST_ACCESS;
                            bus_addr  <= pick_addr;
                            bus_wdata <= pick_wdata;
                            bus_sel   <= pick_sel;
                            bus_read  <= !pick_write;
                            bus_write <= pick_write;
                        end else begin
                            state   <= ST_DONE;
                            m_done  <= pick_grant;
                            m_err   <= pick_grant;
                            m_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!bus_wait || wait_expire) begin
                        state     <= ST_DONE;
                        m_done    <= m_grant;
                        m_err     <= wait_expire ? m_grant : '0;
                        m_rdata   <= (wait_expire || bus_write) ? '0 : bus_rdata;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_sel   <= '0;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        if (wait_expire) wcnt <= WW'(TIMEOUT);
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    m_done  <= '0;
                    m_err   <= '0;
                    m_rdata <= '0;
                    m_grant <= '0;
                    wcnt    <= '0;
                    ptr     <= (int'(lat_idx) == NM - 1) ? '0 : lat_idx + IW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
